wb_regfile: RTL and testbench

Writeback stage and architectural register file for the 8-bit pipeline. It sits directly downstream of the EX/WB pipeline register and consumes that register's outputs: ALU result, instruction code, write-enable and writeback-select. Each cycle it chooses the writeback value, commits it to one of eight 8-bit registers and serves two combinational read ports to decode with same-cycle write bypass. It also holds a one-cycle record of the last committed write for EX-stage forwarding.

---
 rtl/wb_regfile.sv | 65 ++++++
 tb/tb_wb_regfile.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage and 8x8 architectural register file: selects the writeback value,
// commits it, serves two bypassed combinational read ports and a one-cycle forwarding record.
module wb_regfile #(
    parameter logic [7:0] REG_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] aluRes_wb,
    input  logic [7:0] inst_code_wb,
    input  logic       RegWrite_wb,
    input  logic       Sel2_wb,
    input  logic [2:0] rd_addr1,
    input  logic [2:0] rd_addr2,
    output logic [7:0] rd_data1,
    output logic [7:0] rd_data2,
    output logic       fwd_valid,
    output logic [2:0] fwd_addr,
    output logic [7:0] fwd_data
);

    logic [7:0] regs [8];
    logic [7:0] wb_data;
    logic [2:0] wb_addr;
    logic       bypass_en;

    // The opcode is intentionally not decoded here; jump-class suppression arrives via RegWrite_wb.
    logic unused_opcode;
    assign unused_opcode = &{1'b0, inst_code_wb[7:6]};

    assign wb_data   = Sel2_wb ? {{5{inst_code_wb[2]}}, inst_code_wb[2:0]} : aluRes_wb;
    assign wb_addr   = inst_code_wb[5:3];
    assign bypass_en = reset && RegWrite_wb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= REG_RESET;
            end
            fwd_valid <= 1'b0;
            fwd_addr  <= 3'd0;
            fwd_data  <= 8'h00;
        end else begin
            if (RegWrite_wb) begin
                regs[wb_addr] <= wb_data;
            end
            fwd_valid <= RegWrite_wb;
            fwd_addr  <= wb_addr;
            fwd_data  <= wb_data;
        end
    end

    // Forcing REG_RESET while reset is low keeps the read ports clean in the same delta as assertion.
    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
        if (!reset) begin
            rd_data1 = REG_RESET;
            rd_data2 = REG_RESET;
        end else begin
            if (bypass_en && (rd_addr1 == wb_addr)) rd_data1 = wb_data;
            if (bypass_en && (rd_addr2 == wb_addr)) rd_data2 = wb_data;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: reference register model for reads and a
// scoreboard queue of expected forwarding records popped after every clock edge.
module tb_wb_regfile;

    logic       clk;
    logic       reset;
    logic [7:0] aluRes_wb;
    logic [7:0] inst_code_wb;
    logic       RegWrite_wb;
    logic       Sel2_wb;
    logic [2:0] rd_addr1;
    logic [2:0] rd_addr2;
    logic [7:0] rd_data1;
    logic [7:0] rd_data2;
    logic       fwd_valid;
    logic [2:0] fwd_addr;
    logic [7:0] fwd_data;

    typedef struct packed {
        logic       valid;
        logic [2:0] addr;
        logic [7:0] data;
    } fwd_rec_t;

    fwd_rec_t   fwdQ[$];
    logic [7:0] model [8];
    int         checks = 0;
    int         errors = 0;

    wb_regfile #(.REG_RESET(8'h00)) dut (
        .clk          (clk),
        .reset        (reset),
        .aluRes_wb    (aluRes_wb),
        .inst_code_wb (inst_code_wb),
        .RegWrite_wb  (RegWrite_wb),
        .Sel2_wb      (Sel2_wb),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .rd_data1     (rd_data1),
        .rd_data2     (rd_data2),
        .fwd_valid    (fwd_valid),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] wbValue(input logic sel, input logic [7:0] alu, input logic [7:0] inst);
        return sel ? {{5{inst[2]}}, inst[2:0]} : alu;
    endfunction

    task automatic applyStimulus(input logic we, input logic sel, input logic [7:0] alu,
                                 input logic [7:0] inst, input logic [2:0] a1, input logic [2:0] a2);
        RegWrite_wb  = we;
        Sel2_wb      = sel;
        aluRes_wb    = alu;
        inst_code_wb = inst;
        rd_addr1     = a1;
        rd_addr2     = a2;
        #1;
    endtask

    // Push the forwarding record the current inputs should produce, clock, then pop and compare.
    task automatic stepClock();
        fwd_rec_t exp_rec;
        fwd_rec_t got_rec;
        exp_rec.valid = reset && RegWrite_wb;
        exp_rec.addr  = inst_code_wb[5:3];
        exp_rec.data  = wbValue(Sel2_wb, aluRes_wb, inst_code_wb);
        fwdQ.push_back(exp_rec);
        @(posedge clk);
        if (exp_rec.valid) model[exp_rec.addr] = exp_rec.data;
        #1;
        if (fwdQ.size() == 0) begin
            checkOutput("fwd_queue_empty", 8'd0, 8'd1);
        end else begin
            got_rec = fwdQ.pop_front();
            checkOutput("fwd_valid", {7'd0, fwd_valid}, {7'd0, got_rec.valid});
            if (got_rec.valid) begin
                checkOutput("fwd_addr", {5'd0, fwd_addr}, {5'd0, got_rec.addr});
                checkOutput("fwd_data", fwd_data, got_rec.data);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd1);
        checkOutput("reset_rd1", rd_data1, 8'h00);
        checkOutput("reset_fwd_valid", {7'd0, fwd_valid}, 8'h00);
        #11;
        reset = 1'b1;
        stepClock();

        // ALU writeback to R5 with same-cycle bypass
        applyStimulus(1'b1, 1'b0, 8'hA7, 8'b00_101_000, 3'd5, 3'd0);
        checkOutput("alu_bypass_rd1", rd_data1, 8'hA7);
        stepClock();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'b00_000_000, 3'd5, 3'd0);
        checkOutput("alu_array_rd1", rd_data1, 8'hA7);
        checkOutput("alu_model_rd1", rd_data1, model[5]);
        stepClock();

        // Immediate sign extension into R2
        applyStimulus(1'b1, 1'b1, 8'h55, 8'b01_010_110, 3'd2, 3'd2);
        checkOutput("sext_neg_bypass", rd_data1, 8'hFE);
        stepClock();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'd2, 3'd0);
        checkOutput("sext_neg_array", rd_data1, 8'hFE);
        applyStimulus(1'b1, 1'b1, 8'h55, 8'b01_010_011, 3'd2, 3'd2);
        checkOutput("sext_pos_bypass", rd_data2, 8'h03);
        stepClock();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'd2, 3'd0);
        checkOutput("sext_pos_array", rd_data1, 8'h03);

        // Write-disabled cycle must neither commit nor bypass
        applyStimulus(1'b1, 1'b0, 8'h11, 8'b00_100_000, 3'd0, 3'd4);
        stepClock();
        applyStimulus(1'b0, 1'b0, 8'h33, 8'b00_100_000, 3'd0, 3'd4);
        checkOutput("wdis_no_bypass", rd_data2, 8'h11);
        stepClock();
        checkOutput("wdis_array", rd_data2, 8'h11);
        checkOutput("wdis_model", rd_data2, model[4]);

        // Dual-port bypass and back-to-back writes to R7
        applyStimulus(1'b1, 1'b0, 8'hC3, 8'b00_111_000, 3'd7, 3'd7);
        checkOutput("dual_rd1", rd_data1, 8'hC3);
        checkOutput("dual_rd2", rd_data2, 8'hC3);
        stepClock();
        applyStimulus(1'b1, 1'b0, 8'h01, 8'b00_111_000, 3'd7, 3'd7);
        stepClock();
        applyStimulus(1'b1, 1'b0, 8'h02, 8'b00_111_000, 3'd7, 3'd7);
        stepClock();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'd7, 3'd5);
        checkOutput("b2b_last_wins", rd_data1, 8'h02);
        checkOutput("other_reg_kept", rd_data2, 8'hA7);
        stepClock();

        // Asynchronous reset mid-run after R3 = 5A
        applyStimulus(1'b1, 1'b0, 8'h5A, 8'b00_011_000, 3'd3, 3'd7);
        stepClock();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'd3, 3'd7);
        checkOutput("pre_reset_r3", rd_data1, 8'h5A);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        checkOutput("async_rst_rd1", rd_data1, 8'h00);
        checkOutput("async_rst_rd2", rd_data2, 8'h00);
        checkOutput("async_rst_fwd_valid", {7'd0, fwd_valid}, 8'h00);
        checkOutput("async_rst_fwd_addr", {5'd0, fwd_addr}, 8'h00);
        checkOutput("async_rst_fwd_data", fwd_data, 8'h00);

        // Write pending while reset releases
        applyStimulus(1'b1, 1'b0, 8'h44, 8'b00_001_000, 3'd1, 3'd3);
        checkOutput("rst_no_bypass", rd_data1, 8'h00);
        reset = 1'b1;
        #1;
        checkOutput("release_bypass", rd_data1, 8'h44);
        stepClock();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'd1, 3'd3);
        checkOutput("release_commit_r1", rd_data1, 8'h44);
        checkOutput("post_reset_r3", rd_data2, 8'h00);
        stepClock();

        // Short randomized run against the model and the forwarding scoreboard
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom()),
                          8'($urandom()), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if (RegWrite_wb && rd_addr1 == inst_code_wb[5:3])
                checkOutput("rand_rd1", rd_data1, wbValue(Sel2_wb, aluRes_wb, inst_code_wb));
            else
                checkOutput("rand_rd1", rd_data1, model[rd_addr1]);
            if (RegWrite_wb && rd_addr2 == inst_code_wb[5:3])
                checkOutput("rand_rd2", rd_data2, wbValue(Sel2_wb, aluRes_wb, inst_code_wb));
            else
                checkOutput("rand_rd2", rd_data2, model[rd_addr2]);
            stepClock();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
